// File: rtl/ddr_req_arbiter.sv
// Two-port round-robin arbiter in front of a DDR controller command port.
// It grants one request at a time, strobes the command and tracks the busy/done handshake with timeouts.
module ddr_req_arbiter #(
  parameter int unsigned BUSY_WAIT   = 4,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        wr0_i,
  input  logic        wr1_i,
  input  logic [12:0] row0_i,
  input  logic [12:0] row1_i,
  input  logic [1:0]  ba0_i,
  input  logic [1:0]  ba1_i,
  input  logic [9:0]  col0_i,
  input  logic [9:0]  col1_i,
  input  logic        init_done_i,
  input  logic        ctrl_busy_i,
  input  logic        data_out_rdy_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic        rd_valid0_o,
  output logic        rd_valid1_o,
  output logic        err_o,
  output logic        arb_busy_o,
  output logic        addr_strobe_o,
  output logic        rd_wr_req_o,
  output logic [12:0] sys_addr_row_o,
  output logic [1:0]  sys_ba_o,
  output logic [9:0]  sys_addr_col_o
);

  localparam int unsigned ACK_W  = (BUSY_WAIT   > 0) ? $clog2(BUSY_WAIT + 1)   : 1;
  localparam int unsigned DONE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [ACK_W-1:0]  ACK_LIM  = ACK_W'(BUSY_WAIT);
  localparam logic [DONE_W-1:0] DONE_LIM = DONE_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_e;

  state_e             state_q, state_d;
  logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d, ack_inc;
  logic [DONE_W-1:0]  done_cnt_q, done_cnt_d, done_inc;
  // The last granted port is also the owner of the transaction in flight.
  logic               last_grant_q, last_grant_d;

  logic grant_vld, winner, ack_to, done_ok, done_to;

  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        rd_valid0_q, rd_valid0_d, rd_valid1_q, rd_valid1_d;
  logic        err_q, err_d, arb_busy_q, arb_busy_d, addr_strobe_q, addr_strobe_d;
  logic        rd_wr_req_q, rd_wr_req_d;
  logic [12:0] row_q, row_d;
  logic [1:0]  ba_q, ba_d;
  logic [9:0]  col_q, col_d;

  assign ack_inc  = (ack_cnt_q  == ACK_LIM)  ? ack_cnt_q  : ack_cnt_q  + ACK_W'(1);
  assign done_inc = (done_cnt_q == DONE_LIM) ? done_cnt_q : done_cnt_q + DONE_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      ack_cnt_q     <= '0;
      done_cnt_q    <= '0;
      last_grant_q  <= 1'b1;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      rd_valid0_q   <= 1'b0;
      rd_valid1_q   <= 1'b0;
      err_q         <= 1'b0;
      arb_busy_q    <= 1'b0;
      addr_strobe_q <= 1'b0;
      rd_wr_req_q   <= 1'b0;
      row_q         <= '0;
      ba_q          <= '0;
      col_q         <= '0;
    end else begin
      state_q       <= state_d;
      ack_cnt_q     <= ack_cnt_d;
      done_cnt_q    <= done_cnt_d;
      last_grant_q  <= last_grant_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      rd_valid0_q   <= rd_valid0_d;
      rd_valid1_q   <= rd_valid1_d;
      err_q         <= err_d;
      arb_busy_q    <= arb_busy_d;
      addr_strobe_q <= addr_strobe_d;
      rd_wr_req_q   <= rd_wr_req_d;
      row_q         <= row_d;
      ba_q          <= ba_d;
      col_q         <= col_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_cnt_d  = ack_cnt_q;
    done_cnt_d = done_cnt_q;
    grant_vld  = 1'b0;
    winner     = 1'b0;
    ack_to     = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (init_done_i && !ctrl_busy_i && (req0_i || req1_i)) begin
          grant_vld = 1'b1;
          winner    = (req0_i && req1_i) ? ~last_grant_q : req1_i;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d   = WAIT_ACK;
        ack_cnt_d = '0;
      end
      WAIT_ACK: begin
        if (ctrl_busy_i) begin
          state_d    = WAIT_DONE;
          done_cnt_d = '0;
        end else begin
          ack_cnt_d = ack_inc;
          if (ack_inc == ACK_LIM) begin
            ack_to  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!ctrl_busy_i) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else begin
          done_cnt_d = done_inc;
          if (done_inc == DONE_LIM) begin
            done_to = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_grant_d  = grant_vld ? winner : last_grant_q;
    gnt0_d        = grant_vld && !winner;
    gnt1_d        = grant_vld &&  winner;
    addr_strobe_d = grant_vld;
    done0_d       = done_ok && !last_grant_q;
    done1_d       = done_ok &&  last_grant_q;
    err_d         = ack_to || done_to;
    arb_busy_d    = (state_d != IDLE);
    rd_valid0_d   = data_out_rdy_i && !rd_wr_req_q && !last_grant_q &&
                    ((state_q == WAIT_ACK) || (state_q == WAIT_DONE));
    rd_valid1_d   = data_out_rdy_i && !rd_wr_req_q &&  last_grant_q &&
                    ((state_q == WAIT_ACK) || (state_q == WAIT_DONE));
    rd_wr_req_d   = rd_wr_req_q;
    row_d         = row_q;
    ba_d          = ba_q;
    col_d         = col_q;
    if (grant_vld) begin
      rd_wr_req_d = winner ? wr1_i  : wr0_i;
      row_d       = winner ? row1_i : row0_i;
      ba_d        = winner ? ba1_i  : ba0_i;
      col_d       = winner ? col1_i : col0_i;
    end
  end

  assign gnt0_o         = gnt0_q;
  assign gnt1_o         = gnt1_q;
  assign done0_o        = done0_q;
  assign done1_o        = done1_q;
  assign rd_valid0_o    = rd_valid0_q;
  assign rd_valid1_o    = rd_valid1_q;
  assign err_o          = err_q;
  assign arb_busy_o     = arb_busy_q;
  assign addr_strobe_o  = addr_strobe_q;
  assign rd_wr_req_o    = rd_wr_req_q;
  assign sys_addr_row_o = row_q;
  assign sys_ba_o       = ba_q;
  assign sys_addr_col_o = col_q;

endmodule

// File: doc/ddr_req_arbiter.md
DDR_REQ_ARBITER -- requirements
Module: ddr_req_arbiter

Interface
REQ-001 Parameter: BUSY_WAIT, 4, max cycles in WAIT_ACK for ctrl_busy to assert after the strobe.
REQ-002 Parameter: TIMEOUT_CYC, 1023, max cycles in WAIT_DONE for ctrl_busy to deassert.
REQ-003 The block SHALL have a single clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req0, req1  in  1 each  access request from port 0 / port 1.
REQ-007 wr0, wr1  in  1 each  1 = write, 0 = read.
REQ-008 row0, row1  in  13 each; ba0, ba1  in  2 each; col0, col1  in  10 each  request address.
REQ-009 gnt0, gnt1  out  1 each  one-cycle grant pulse.
REQ-010 done0, done1  out  1 each  one-cycle completion pulse.
REQ-011 rd_valid0, rd_valid1  out  1 each  read data valid for the owning port.
REQ-012 err  out  1  one-cycle pulse on handshake timeout.
REQ-013 arb_busy  out  1  high in every state except IDLE.
REQ-014 init_done, ctrl_busy, data_out_rdy  in  1 each  controller status.
REQ-015 addr_strobe  out  1; rd_wr_req  out  1; sys_addr_row  out  13; sys_ba  out  2; sys_addr_col  out  10  controller command port.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE. All outputs are registered.
REQ-017 IDLE: if init_done=1, ctrl_busy=0, and (req0 or req1)=1, select a winner, latch its wr/row/ba/col into rd_wr_req/sys_addr_row/sys_ba/sys_addr_col, pulse the winner's gnt for one cycle, record owner, and go to ISSUE.
REQ-018 Arbitration: when only one port requests, it wins. When both request, the port not granted most recently wins (round-robin). last_grant updates on every grant.
REQ-019 While init_done=0 or ctrl_busy=1 in IDLE, no grant is issued and requests stay pending.
REQ-020 ISSUE: addr_strobe=1 for exactly one cycle; command outputs stay stable; go to WAIT_ACK with counter cleared.
REQ-021 WAIT_ACK: when ctrl_busy=1, go to WAIT_DONE with counter cleared. If the counter reaches BUSY_WAIT without ctrl_busy, pulse err and go to IDLE; no done is issued.
REQ-022 WAIT_DONE: when ctrl_busy=0, pulse done of the owner for one cycle and go to IDLE. If the counter reaches TIMEOUT_CYC, pulse err, pulse no done, and go to IDLE.
REQ-023 rd_valid(owner) = registered data_out_rdy AND rd_wr_req=0 AND state in {WAIT_ACK, WAIT_DONE}. The non-owner's rd_valid stays 0. data_out_rdy outside these states is ignored.
REQ-024 Command outputs hold their last latched values until the next grant.
REQ-025 Requests are sampled only in IDLE. A requester keeps req and its fields stable until it sees gnt. A req dropped before gnt is never served. A req still high after done is re-arbitrated.
REQ-026 Counters are sized by clog2(max parameter+1). They saturate and never wrap.
REQ-027 Earliest re-grant is the cycle after done/err, giving a minimum back-to-back spacing of 4 cycles between addr_strobe pulses.

Reset
REQ-028 While rst=0, regardless of clock: state=IDLE; gnt*, done*, rd_valid*, err, addr_strobe, arb_busy = 0; command outputs = 0; counters = 0; last_grant = port 1, so port 0 wins the first contention.
REQ-029 Reset asserted mid-transaction aborts it at once with no done/err pulse. After release, the block waits in IDLE for ctrl_busy=0 before granting.

Verification
REQ-030 After reset, init_done=1, req0=req1=1 -> gnt0 pulses first, and strobe carries row0/ba0/col0. After done0 -> gnt1 pulses. Further contention alternates 0,1,0,...
REQ-031 req1 only, wr1=1, row1=0x1ABC, ba1=2, col1=0x155; ctrl_busy rises 2 cycles after strobe and falls after 20 -> one-cycle addr_strobe with rd_wr_req=1 and matching fields; done1 pulses 1 cycle after ctrl_busy falls; arb_busy low afterwards.
REQ-032 Read on port 0 with data_out_rdy pulsed 3 times during WAIT_DONE -> rd_valid0 pulses 3 times (1-cycle lag); rd_valid1 stays 0.
REQ-033 ctrl_busy never asserts after strobe -> err pulses exactly BUSY_WAIT cycles after WAIT_ACK entry; no done; return to IDLE. Likewise, ctrl_busy stuck high -> err after TIMEOUT_CYC.
REQ-034 init_done=0 with req0 high for 100 cycles -> no gnt or strobe. init_done rises -> gnt0 next cycle.
REQ-035 rst pulsed low during WAIT_DONE -> all outputs 0 immediately, no done. Post-reset grant waits until ctrl_busy=0.
